mux_8x1_rr_sched: RTL and testbench
===================================

// Module: mux_8x1_rr_sched
// PURPOSE
//   Round-robin scheduler that shares one 8:1 single-bit mux path among 8 requesters.
//   Arbitrates req[7:0], drives a registered 3-bit select plus one-hot grant, and
//   caps each owner at MAX_BURST consecutive cycles. It gates the muxed bit to y.
//   It sits in front of an 8x1 mux, or uses its own internal equivalent.
// PARAMETERS
//   MAX_BURST  4  max consecutive cycles one owner holds the path; legal range 1..255
// PORTS
//   clk    input   1  single clock, rising edge
//   rst    input   1  asynchronous reset, active-high
//   req    input   8  request per source; req[i] high = source i wants the path
//   in     input   8  data bit per source; in[i] belongs to source i
//   sel    output  3  registered mux select = index of current owner
//   grant  output  8  registered one-hot grant; all-zero when idle
//   busy   output  1  registered; high while a grant is active
//   y      output  1  combinational: busy ? in[sel] : 1'b0
// BEHAVIOUR
//   - Reset (async, immediate, also mid-burst):
//     sel=0, grant=0, busy=0, y=0, state=IDLE, burst count=0, last-owner pointer=7.
//     After reset the first search starts at index 0.
//   - Counter width is $clog2(MAX_BURST+1). The counter must not wrap past MAX_BURST.
//   - Round-robin search: priority starts at (last_owner+1) mod 8 and wraps through 7->0.
//     The last owner is lowest priority and is still eligible.
//   - FSM states: IDLE, GRANT (plus GAP with the macro).
//   - IDLE:
//     - If any req is high, go to GRANT on the next edge with the winner's sel and grant.
//     - Set busy=1, count=1, last_owner=winner.
//     - Latency: req high in cycle N -> grant visible in cycle N+1.
//   - GRANT, owner keeps the path when req[sel]=1 and count<MAX_BURST:
//     count increments and outputs are unchanged.
//   - GRANT, burst ends when req[sel]=0 or count==MAX_BURST:
//     - Rearbitrate on the same edge.
//     - If any req is high, switch back-to-back to the RR winner (count=1).
//     - The old owner wins again only if no other source is requesting.
//     - Otherwise go to IDLE with grant=0, busy=0, sel held at its last value.
//   - MAX_BURST=1: the owner rotates every cycle whenever there are multiple requesters.
//   - A request that drops and rises while the source is not owner is ignored until the
//     next arbitration. There is no request latching.
//   - Owner drops req in the same cycle another source raises req:
//     the new source is granted next cycle if it is RR-first.
//   - Grant is always one-hot or zero. sel always matches the grant index when busy=1.
// CONFIGURATION
//   MUX_SCHED_GAP_EN
//     - Defined: every ownership change (owner A -> owner B, A != B) passes through
//       one GAP cycle with grant=0, busy=0, y=0.
//     - After GAP, arbitration is re-evaluated from fresh req; the pointer advances past A.
//     - Re-grant to the same owner has no gap. IDLE->GRANT has no gap.
//     - Not defined: switches are back-to-back with no GAP state.
//       This is the default.
// TESTING
//   1. Reset then req=8'h01 held: cycle 1 grant=01, sel=0, busy=1. With MAX_BURST=4 and
//      no other req, the owner is re-granted every 4 cycles with no bubble. y follows in[0].
//   2. req=8'hFF constant, MAX_BURST=4: grant sequence 01,02,04,...,80,01, each held
//      exactly 4 cycles.
//   3. req=8'h81, owner 7 drops req after 2 cycles: next cycle grant=01, sel=0.
//      The search wraps 7->0. Check y=in[0].
//   4. req=8'h24 with MAX_BURST=1: grant alternates 04,20,04,20 every cycle.
//   5. Assert rst mid-burst (grant=08): outputs are 0 immediately, before the clock edge.
//      After release with req=8'h08, the first grant=08 arrives one cycle later.
//   6. With MUX_SCHED_GAP_EN defined and req=8'h03, MAX_BURST=2: grant 01,01,00,02,02,00,01.
//      y=0 in the gap cycles.

Source files
------------

// File: rtl/mux_8x1_rr_sched.sv
// Round-robin scheduler sharing one 8:1 single-bit mux path among 8 requesters.
// Each owner holds the path for at most MAX_BURST consecutive cycles.
// Optional macro MUX_SCHED_GAP_EN: inserts one idle GAP cycle on every
// change of owner (A -> B, A != B).
module mux_8x1_rr_sched #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic [7:0] in,
  output logic [2:0] sel,
  output logic [7:0] grant,
  output logic       busy,
  output logic       y
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
  localparam int unsigned N_SRC = 8;

`ifdef MUX_SCHED_GAP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, GAP = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1} state_t;
`endif

  state_t           state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic [7:0]       grant_q, grant_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       last_q, last_d;

  logic [2:0]       win_c;
  logic             any_c;
  logic             hold_c;

  // Round-robin pick: search starts just after the last owner, wraps 7->0,
  // so the last owner is lowest priority but still eligible.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] last);
    logic [2:0] idx;
    logic [2:0] pick;
    pick = last;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      idx = 3'(last + 3'(i) + 3'd1);
      if (r[idx]) pick = idx;
    end
    return pick;
  endfunction

  // Arbitration inputs shared by all states.
  always_comb begin
    any_c  = |req;
    win_c  = rr_pick(req, last_q);
    hold_c = req[sel_q] && (cnt_q < CNT_W'(MAX_BURST));
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    last_d  = last_q;

    case (state_q)
      IDLE: begin
        if (any_c) begin
          state_d = GRANT;
          sel_d   = win_c;
          grant_d = 8'h01 << win_c;
          busy_d  = 1'b1;
          cnt_d   = CNT_W'(1);
          last_d  = win_c;
        end
      end

      GRANT: begin
        if (hold_c) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else if (any_c) begin
`ifdef MUX_SCHED_GAP_EN
          if (win_c != sel_q) begin
            // Owner change: one dead cycle; last_q already points at the old owner.
            state_d = GAP;
            grant_d = '0;
            busy_d  = 1'b0;
            cnt_d   = '0;
          end else begin
            state_d = GRANT;
            grant_d = 8'h01 << win_c;
            busy_d  = 1'b1;
            cnt_d   = CNT_W'(1);
            last_d  = win_c;
          end
`else
          state_d = GRANT;
          sel_d   = win_c;
          grant_d = 8'h01 << win_c;
          busy_d  = 1'b1;
          cnt_d   = CNT_W'(1);
          last_d  = win_c;
`endif
        end else begin
          state_d = IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end
      end

`ifdef MUX_SCHED_GAP_EN
      GAP: begin
        // Re-arbitrate from fresh requests after the dead cycle.
        if (any_c) begin
          state_d = GRANT;
          sel_d   = win_c;
          grant_d = 8'h01 << win_c;
          busy_d  = 1'b1;
          cnt_d   = CNT_W'(1);
          last_d  = win_c;
        end else begin
          state_d = IDLE;
        end
      end
`endif

      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      last_q  <= 3'd7;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  assign sel   = sel_q;
  assign grant = grant_q;
  assign busy  = busy_q;

  // Gated mux output.
  assign y = busy_q & in[sel_q];

endmodule

// File: tb/tb_mux_8x1_rr_sched.sv
// Directed bench for mux_8x1_rr_sched: burst 4 (main), burst 1 (rotation), burst 2 (gap option).
module tb_mux_8x1_rr_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic [7:0] req_a, req_b, req_c;
  logic [2:0] sel_a, sel_b, sel_c;
  logic [7:0] grant_a, grant_b, grant_c;
  logic       busy_a, busy_b, busy_c;
  logic       y_a, y_b, y_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_8x1_rr_sched #(.MAX_BURST(4)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .in(din),
    .sel(sel_a), .grant(grant_a), .busy(busy_a), .y(y_a));

  mux_8x1_rr_sched #(.MAX_BURST(1)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .in(din),
    .sel(sel_b), .grant(grant_b), .busy(busy_b), .y(y_b));

  mux_8x1_rr_sched #(.MAX_BURST(2)) dut_c (
    .clk(clk), .rst(rst), .req(req_c), .in(din),
    .sel(sel_c), .grant(grant_c), .busy(busy_c), .y(y_c));

  typedef struct {
    logic [7:0] req;
    logic [7:0] din;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       busy;
    logic       y;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    req_a = '0;
    req_b = '0;
    req_c = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] e;
    logic [7:0] seq_c [7];

    rst = 1'b1;
    din = 8'hFF;
    req_a = '0; req_b = '0; req_c = '0;

    // req, in, grant, sel, busy, y (MAX_BURST=4, starting right after reset)
    vecs[0]  = '{8'h01, 8'h01, 8'h01, 3'd0, 1'b1, 1'b1};
    vecs[1]  = '{8'h01, 8'h00, 8'h01, 3'd0, 1'b1, 1'b0};
    vecs[2]  = '{8'h01, 8'h01, 8'h01, 3'd0, 1'b1, 1'b1};
    vecs[3]  = '{8'h01, 8'h00, 8'h01, 3'd0, 1'b1, 1'b0};
    vecs[4]  = '{8'h01, 8'h01, 8'h01, 3'd0, 1'b1, 1'b1};
    vecs[5]  = '{8'h00, 8'h01, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[6]  = '{8'h81, 8'h80, 8'h80, 3'd7, 1'b1, 1'b1};
    vecs[7]  = '{8'h81, 8'h00, 8'h80, 3'd7, 1'b1, 1'b0};
    vecs[8]  = '{8'h01, 8'h01, 8'h01, 3'd0, 1'b1, 1'b1};
    vecs[9]  = '{8'h00, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[10] = '{8'h04, 8'h04, 8'h04, 3'd2, 1'b1, 1'b1};
    vecs[11] = '{8'h10, 8'h00, 8'h10, 3'd4, 1'b1, 1'b0};
    vecs[12] = '{8'h10, 8'h10, 8'h10, 3'd4, 1'b1, 1'b1};
    vecs[13] = '{8'h18, 8'h10, 8'h10, 3'd4, 1'b1, 1'b1};
    vecs[14] = '{8'h18, 8'h00, 8'h10, 3'd4, 1'b1, 1'b0};
    vecs[15] = '{8'h18, 8'h08, 8'h08, 3'd3, 1'b1, 1'b1};
    vecs[16] = '{8'h00, 8'h00, 8'h00, 3'd3, 1'b0, 1'b0};

    // Reset state, with all data bits high so y would show any leak.
    #12;
    chk("rst_grant", grant_a, 8'h00);
    chk("rst_sel",   8'(sel_a), 8'h00);
    chk("rst_busy",  8'(busy_a), 8'h00);
    chk("rst_y",     8'(y_a), 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven main sequence.
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      req_a = vecs[k].req;
      din   = vecs[k].din;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_grant", k), grant_a, vecs[k].grant);
      chk($sformatf("vec%0d_sel", k), 8'(sel_a), 8'(vecs[k].sel));
      chk($sformatf("vec%0d_busy", k), 8'(busy_a), 8'(vecs[k].busy));
      chk($sformatf("vec%0d_y", k), 8'(y_a), 8'(vecs[k].y));
    end

    // All requesting: each source holds exactly 4 cycles, rotating 0..7 then 0 again.
    do_reset();
    din   = 8'hFF;
    req_a = 8'hFF;
    for (int k = 0; k < 36; k++) begin
      @(posedge clk);
      #1;
      e = 8'h01 << 3'((k / 4) % 8);
      chk($sformatf("ff_c%0d_grant", k), grant_a, e);
      chk($sformatf("ff_c%0d_sel", k), 8'(sel_a), 8'((k / 4) % 8));
    end

    // Asynchronous reset mid-burst, then re-grant one cycle after release.
    do_reset();
    req_a = 8'h08;
    @(posedge clk);
    #1;
    chk("mid_grant_pre", grant_a, 8'h08);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_grant_rst", grant_a, 8'h00);
    chk("mid_busy_rst",  8'(busy_a), 8'h00);
    chk("mid_y_rst",     8'(y_a), 8'h00);
    chk("mid_sel_rst",   8'(sel_a), 8'h00);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_grant_post", grant_a, 8'h08);
    chk("mid_sel_post",   8'(sel_a), 8'h03);

    // MAX_BURST=1: two requesters alternate every cycle.
    do_reset();
    req_b = 8'h24;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      e = (k % 2 == 0) ? 8'h04 : 8'h20;
      chk($sformatf("b1_c%0d_grant", k), grant_b, e);
      chk($sformatf("b1_c%0d_y", k), 8'(y_b), 8'h01);
    end

    // MAX_BURST=2 with two requesters: gap cycles only with the option enabled.
`ifdef MUX_SCHED_GAP_EN
    seq_c = '{8'h01, 8'h01, 8'h00, 8'h02, 8'h02, 8'h00, 8'h01};
`else
    seq_c = '{8'h01, 8'h01, 8'h02, 8'h02, 8'h01, 8'h01, 8'h02};
`endif
    do_reset();
    req_c = 8'h03;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("b2_c%0d_grant", k), grant_c, seq_c[k]);
      chk($sformatf("b2_c%0d_busy", k), 8'(busy_c), 8'(seq_c[k] != 8'h00));
      chk($sformatf("b2_c%0d_y", k), 8'(y_c), 8'(seq_c[k] != 8'h00));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
